// File: rtl/adc0809_responder.sv
// Behavioural responder for an ADC0809-style 8-channel converter.
// Mimics the chip's ale/st/oe/eoc handshake and runs an ideal 8-bit
// successive-approximation search paced by the controller's clk_adc.
module adc0809_responder #(
    parameter int unsigned TICKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_adc,
    input  logic        ale,
    input  logic        st,
    input  logic        oe,
    input  logic [2:0]  addr,
    input  logic [63:0] ain,
    output logic        eoc,
    output logic [7:0]  dout,
    output logic        dout_en,
    output logic        busy
);

    localparam int unsigned TickW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStartHeld,
        StConvert
    } state_e;

    state_e           state_q;
    logic             clk_adc_q, clk_adc_prev_q;
    logic             ale_q, ale_prev_q;
    logic             st_q, st_prev_q;
    logic             oe_q;
    logic [2:0]       chan_q;
    logic [7:0]       sample_q;
    logic [7:0]       sar_q;
    logic [7:0]       result_q;
    logic [2:0]       bit_idx_q;
    logic [TickW-1:0] tick_q;
    logic             eoc_q;

    logic       adc_rise, ale_rise, st_rise, st_fall;
    logic [7:0] sample_sel;
    logic [7:0] trial;
    logic [7:0] sar_d;

    // Register the asynchronous control inputs once and keep the previous value for edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_adc_q      <= 1'b0;
            clk_adc_prev_q <= 1'b0;
            ale_q          <= 1'b0;
            ale_prev_q     <= 1'b0;
            st_q           <= 1'b0;
            st_prev_q      <= 1'b0;
            oe_q           <= 1'b0;
        end else begin
            clk_adc_q      <= clk_adc;
            clk_adc_prev_q <= clk_adc_q;
            ale_q          <= ale;
            ale_prev_q     <= ale_q;
            st_q           <= st;
            st_prev_q      <= st_q;
            oe_q           <= oe;
        end
    end

    // Edge strobes, selected channel and the current SAR trial decision.
    always_comb begin
        adc_rise   = clk_adc_q & ~clk_adc_prev_q;
        ale_rise   = ale_q & ~ale_prev_q;
        st_rise    = st_q & ~st_prev_q;
        st_fall    = ~st_q & st_prev_q;
        sample_sel = ain[{chan_q, 3'b000} +: 8];
        trial      = sar_q | (8'h01 << bit_idx_q);
        sar_d      = (trial <= sample_q) ? trial : sar_q;
    end

    // Channel register only moves on an ale rising edge, even mid-conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q <= 3'd0;
        end else if (ale_rise) begin
            chan_q <= addr;
        end
    end

    // Conversion FSM: st rise always (re)arms, st fall samples, clk_adc paces the search.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            eoc_q     <= 1'b1;
            sample_q  <= 8'h00;
            sar_q     <= 8'h00;
            result_q  <= 8'h00;
            bit_idx_q <= 3'd0;
            tick_q    <= '0;
        end else if (st_rise) begin
            // Abort whatever is in flight; the result latch is deliberately left alone.
            state_q   <= StStartHeld;
            eoc_q     <= 1'b0;
            bit_idx_q <= 3'd0;
            tick_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StStartHeld: begin
                    if (st_fall) begin
                        state_q   <= StConvert;
                        sample_q  <= sample_sel;
                        sar_q     <= 8'h00;
                        bit_idx_q <= 3'd7;
                        tick_q    <= '0;
                    end
                end
                StConvert: begin
                    if (adc_rise) begin
                        if (tick_q == TickLast) begin
                            tick_q <= '0;
                            sar_q  <= sar_d;
                            if (bit_idx_q == 3'd0) begin
                                result_q <= sar_d;
                                eoc_q    <= 1'b1;
                                state_q  <= StIdle;
                            end else begin
                                bit_idx_q <= bit_idx_q - 3'd1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are pure functions of registered state.
    always_comb begin
        eoc     = eoc_q;
        busy    = (state_q != StIdle);
        dout_en = oe_q;
        dout    = oe_q ? result_q : 8'h00;
    end

endmodule

// File: tb/tb_adc0809_responder.sv
// Self-checking bench for adc0809_responder: expected conversion results are
// queued when st falls and compared against dout once eoc rises.
module tb_adc0809_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_adc, ale, st, oe;
    logic [2:0]  addr;
    logic [63:0] ain;
    logic        eoc, dout_en, busy;
    logic [7:0]  dout;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    adc0809_responder #(.TICKS_PER_BIT(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_adc (clk_adc),
        .ale     (ale),
        .st      (st),
        .oe      (oe),
        .addr    (addr),
        .ain     (ain),
        .eoc     (eoc),
        .dout    (dout),
        .dout_en (dout_en),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic [7:0] val);
        ain[ch*8 +: 8] = val;
    endtask

    task automatic pulse_ale(input logic [2:0] ch);
        addr = ch;
        ale  = 1'b1;
        cyc(3);
        ale  = 1'b0;
        cyc(3);
    endtask

    task automatic st_up();
        st = 1'b1;
        cyc(3);
    endtask

    // Falling st is where the responder samples, so the expectation is queued here.
    task automatic st_down(input logic [7:0] exp);
        st = 1'b0;
        exp_q.push_back(exp);
        cyc(3);
    endtask

    task automatic tick();
        clk_adc = 1'b1;
        cyc(2);
        clk_adc = 1'b0;
        cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Tick until eoc rises (bounded), check tick count, then pop and compare the result.
    task automatic wait_done(input string tag, input int exp_ticks);
        int n;
        logic [7:0] exp;
        n = 0;
        while (!eoc && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_ticks"}, n, exp_ticks);
        chk({tag, "_eoc"}, eoc, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        oe = 1'b1;
        cyc(3);
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_dout_en"}, dout_en, 1'b1);
        oe = 1'b0;
        cyc(3);
        chk({tag, "_dout_off"}, dout, 8'h00);
    endtask

    task automatic convert(input string tag, input logic [2:0] ch, input logic [7:0] val);
        set_ch(ch, val);
        pulse_ale(ch);
        st_up();
        chk({tag, "_eoc_low"}, eoc, 1'b0);
        chk({tag, "_busy_hi"}, busy, 1'b1);
        st_down(val);
        wait_done(tag, 64);
    endtask

    initial begin
        int eoc_low_seen;
        reset = 1'b1;
        clk_adc = 1'b0; ale = 1'b0; st = 1'b0; oe = 1'b0;
        addr = 3'd0; ain = '0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        chk("rst_eoc", eoc, 1'b1);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_en", dout_en, 1'b0);
        chk("rst_busy", busy, 1'b0);

        convert("ch3_a5", 3'd3, 8'hA5);
        convert("ch0_00", 3'd0, 8'h00);
        convert("ch7_ff", 3'd7, 8'hFF);
        convert("ch5_80", 3'd5, 8'h80);
        convert("ch6_5b", 3'd6, 8'h5B);

        // Ticks while idle must not start or disturb anything.
        ticks(10);
        chk("idle_eoc", eoc, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Restart mid-conversion: latch keeps 5B until the new conversion completes.
        set_ch(1, 8'h33);
        pulse_ale(3'd1);
        st_up();
        st_down(8'h33);
        ticks(30);
        st_up();
        void'(exp_q.pop_back());
        chk("restart_eoc_low", eoc, 1'b0);
        chk("restart_busy", busy, 1'b1);
        set_ch(1, 8'h44);
        oe = 1'b1;
        cyc(3);
        chk("restart_old_latch", dout, 8'h5B);
        oe = 1'b0;
        st_down(8'h44);
        wait_done("restart", 64);

        // Sample hold: input change after st fall is ignored.
        set_ch(2, 8'h10);
        pulse_ale(3'd2);
        st_up();
        st_down(8'h10);
        ticks(5);
        set_ch(2, 8'hF0);
        wait_done("hold", 59);

        // ale mid-conversion moves chan but not the sample already taken.
        set_ch(4, 8'h5A);
        set_ch(6, 8'h3C);
        pulse_ale(3'd4);
        st_up();
        st_down(8'h5A);
        ticks(10);
        pulse_ale(3'd6);
        wait_done("ale_mid", 54);
        st_up();
        st_down(8'h3C);
        wait_done("ale_next", 64);

        // Reset at tick 40 aborts immediately and nothing resumes afterwards.
        set_ch(3, 8'hC3);
        pulse_ale(3'd3);
        st_up();
        st_down(8'hC3);
        void'(exp_q.pop_back());
        ticks(40);
        oe = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_mid_async_eoc", eoc, 1'b1);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("rst_mid_eoc", eoc, 1'b1);
        chk("rst_mid_dout", dout, 8'h00);
        chk("rst_mid_busy", busy, 1'b0);
        oe = 1'b0;
        eoc_low_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (!eoc) eoc_low_seen = 1;
        end
        chk("rst_mid_no_eoc_change", eoc_low_seen, 0);

        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc0809_responder.md
ADC0809_RESPONDER -- requirements
Module: adc0809_responder

Interface
REQ-001 Parameter TICKS_PER_BIT, default 8, meaning clk_adc rising edges per successive-approximation bit (conversion = 8*TICKS_PER_BIT ticks).
REQ-002 clk  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 clk_adc  input  1  converter clock from the ADC controller; a rising edge = one tick.
REQ-005 ale  input  1  address latch enable.
REQ-006 st  input  1  start of conversion.
REQ-007 oe  input  1  output enable.
REQ-008 addr  input  3  channel select.
REQ-009 ain  input  64  eight 8-bit analog-equivalent channel values; channel n = ain[8n+7:8n].
REQ-010 eoc  output  1  end of conversion; high = idle/result valid.
REQ-011 dout  output  8  conversion result when oe high, else 8'h00.
REQ-012 dout_en  output  1  registered copy of oe; board-level tristate enable.
REQ-013 busy  output  1  high in START_HELD or CONVERT.

Function
REQ-014 clk_adc, ale, st, oe shall each be registered once in the clk domain; edge detection shall compare the registered value to the previous registered value.
REQ-015 ale rising edge shall latch addr into channel register chan; chan shall not change at any other time.
REQ-016 FSM states: IDLE, START_HELD, CONVERT.
REQ-017 IDLE -> START_HELD on st rising edge; eoc shall go low on the clk cycle the edge is detected.
REQ-018 st rising edge in any state (incl. CONVERT) shall abort any conversion, clear the tick/bit counters, enter START_HELD, drive eoc low.
REQ-019 START_HELD -> CONVERT on st falling edge; same cycle: sample <= ain[chan], sar <= 8'h00, bit index <= 7, tick count <= 0.
REQ-020 In CONVERT, each clk_adc rising edge increments tick count; on the TICKS_PER_BIT-th tick of a bit: trial = sar with bit[index] set; sar <= trial if trial <= sample, else unchanged; tick count <= 0; index decrements.
REQ-021 After the bit-0 decision (tick 8*TICKS_PER_BIT after CONVERT entry): result latch <= final sar, eoc <= 1, state -> IDLE, all on the same clk cycle.
REQ-022 Final sar shall equal sample exactly (ideal 8-bit converter, unsigned compare, 8-bit arithmetic, no overflow).
REQ-023 ain changes during CONVERT shall not affect the result; only the value sampled in REQ-019 counts.
REQ-024 ale rising edge during CONVERT shall update chan but not the current sample.
REQ-025 Result latch shall hold its value until the next completed conversion; an aborted conversion leaves it unchanged.
REQ-026 dout = result latch when registered oe = 1, else 8'h00; dout_en = registered oe; both independent of FSM state.
REQ-027 clk_adc ticks in IDLE or START_HELD shall be ignored.
REQ-028 busy = 1 in START_HELD and CONVERT, 0 in IDLE.

Reset
REQ-029 On reset: state IDLE, eoc = 1, dout = 8'h00, dout_en = 0, busy = 0, chan = 0, sample = 0, sar = 0, result latch = 8'h00, counters = 0, all synchronizer/edge registers = 0.
REQ-030 Reset asserted mid-conversion shall abort immediately; after release the block behaves as after power-up and starts no conversion until a new st rising edge.

Verification
REQ-031 ain ch3 = 8'hA5; pulse ale with addr=3, pulse st; after 64 clk_adc ticks eoc rises; oe=1 -> dout=8'hA5, dout_en=1; oe=0 -> dout=8'h00.
REQ-032 Boundary values: ch0 = 8'h00 -> result 8'h00; ch7 = 8'hFF -> result 8'hFF; ch5 = 8'h80 -> result 8'h80; each exactly 64 ticks after st falling.
REQ-033 Restart: st re-pulsed after 30 ticks of a ch1 = 8'h33 conversion, ain ch1 changed to 8'h44 before st falls -> eoc stays low, result 8'h44 after 64 ticks from second st fall; previous latch unchanged until then.
REQ-034 Sample hold: ch2 = 8'h10 at st fall, changed to 8'hF0 after 5 ticks -> result 8'h10.
REQ-035 Reset at tick 40 of a conversion -> eoc=1, dout=8'h00, busy=0 next cycle; no eoc transition afterwards without a new st.
REQ-036 Closed loop with the ADC controller (clk_adc at 500 kHz, ch0 = 8'd200): controller captures 200, dataR1 = 80, BCD digits 0/8/0.
